uart_brg_frac: RTL and testbench

Runtime-programmable fractional baud-rate generator for the UART: the next generation of the fixed-period generator. It produces an oversampling tick (`sample_tick`) at clk/(div_int + div_frac/2^FRAC_WIDTH) and a bit tick (`baud_tick`) every OVERSAMPLE sample ticks. The divisor can be reloaded glitch-free at run time, and the sample phase can be resynchronised by the receiver. It sits between the clock domain and the UART rx/tx engines, which consume the ticks and the sample index.

---
 rtl/uart_brg_frac_pkg.sv | 23 ++
 rtl/uart_brg_frac_if.sv | 32 +++
 rtl/uart_brg_frac_acc.sv | 37 +++
 rtl/uart_brg_frac.sv | 110 +++++++++++
 tb/tb_uart_brg_frac.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_brg_frac_pkg.sv
// Shared constants and helpers for the fractional UART baud-rate generator.
// Defaults reproduce 115200 baud x16 from a 600 MHz clock (325.5 cycles per sample).
package uart_brg_frac_pkg;

  localparam int unsigned BRG_INT_WIDTH    = 16;
  localparam int unsigned BRG_FRAC_WIDTH   = 4;
  localparam int unsigned BRG_OVERSAMPLE   = 16;
  localparam int unsigned BRG_DEFAULT_INT  = 325;
  localparam int unsigned BRG_DEFAULT_FRAC = 8;

  // Width of the sample index within a bit.
  function automatic int unsigned idx_width(input int unsigned oversample);
    return (oversample <= 2) ? 1 : $clog2(oversample);
  endfunction

  // Where the next active divisor comes from at an apply point.
  typedef enum logic [1:0] {
    APPLY_NONE,
    APPLY_SHADOW,
    APPLY_INPUT
  } apply_src_e;

endpackage

// File: rtl/uart_brg_frac_if.sv
// Control and tick bundle between the baud-rate generator and its UART engines.
interface uart_brg_frac_if #(
  parameter int unsigned INT_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned OVERSAMPLE = 16
);
  import uart_brg_frac_pkg::*;

  localparam int unsigned IDX_W = idx_width(OVERSAMPLE);

  logic                  enable;
  logic                  sync_clear;
  logic                  div_load;
  logic [INT_WIDTH-1:0]  div_int;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic                  sample_tick;
  logic                  baud_tick;
  logic [IDX_W-1:0]      sample_index;
  logic [INT_WIDTH:0]    period_count;
  logic                  div_pending;

  modport master (
    output enable, sync_clear, div_load, div_int, div_frac,
    input  sample_tick, baud_tick, sample_index, period_count, div_pending
  );

  modport slave (
    input  enable, sync_clear, div_load, div_int, div_frac,
    output sample_tick, baud_tick, sample_index, period_count, div_pending
  );

endinterface

// File: rtl/uart_brg_frac_acc.sv
// Fractional accumulator: spreads div_frac/2^FRAC_WIDTH over periods as an
// extra cycle whenever the previous accumulate overflowed.
module uart_brg_frac_acc
  import uart_brg_frac_pkg::*;
#(
  parameter int unsigned INT_WIDTH  = BRG_INT_WIDTH,
  parameter int unsigned FRAC_WIDTH = BRG_FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [INT_WIDTH-1:0]  act_int,
  input  logic [FRAC_WIDTH-1:0] add_frac,
  output logic [INT_WIDTH:0]    len
);

  logic [FRAC_WIDTH-1:0] frac_acc;
  logic                  carry;
  logic [INT_WIDTH-1:0]  eff_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frac_acc <= '0;
      carry    <= 1'b0;
    end else if (clear) begin
      frac_acc <= '0;
      carry    <= 1'b0;
    end else if (advance) begin
      {carry, frac_acc} <= {1'b0, frac_acc} + {1'b0, add_frac};
    end
  end

  assign eff_int = (act_int == '0) ? INT_WIDTH'(1) : act_int;
  assign len     = {1'b0, eff_int} + (INT_WIDTH + 1)'(carry);

endmodule

// File: rtl/uart_brg_frac.sv
// Runtime-programmable fractional baud-rate generator: sample and bit ticks,
// glitch-free divisor reload at period boundaries, receiver phase resync.
module uart_brg_frac
  import uart_brg_frac_pkg::*;
#(
  parameter int unsigned INT_WIDTH    = BRG_INT_WIDTH,
  parameter int unsigned FRAC_WIDTH   = BRG_FRAC_WIDTH,
  parameter int unsigned OVERSAMPLE   = BRG_OVERSAMPLE,
  parameter int unsigned DEFAULT_INT  = BRG_DEFAULT_INT,
  parameter int unsigned DEFAULT_FRAC = BRG_DEFAULT_FRAC
) (
  input  logic            clk,
  input  logic            reset,
  uart_brg_frac_if.slave  brg
);

  localparam int unsigned      IDX_W    = idx_width(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

  logic [INT_WIDTH-1:0]  act_int, shd_int, nxt_int;
  logic [FRAC_WIDTH-1:0] act_frac, shd_frac, nxt_frac;
  logic                  pending;
  logic [INT_WIDTH:0]    period_count, len;
  logic [IDX_W-1:0]      sample_index;
  logic                  sample_tick, boundary;
  apply_src_e            apply_src;

  // >= rather than == also releases a count stranded past a shorter divisor
  // that was applied while the generator was disabled.
  assign sample_tick = brg.enable & ~brg.sync_clear & (period_count >= len - 1'b1);
  assign boundary    = sample_tick | ~brg.enable | brg.sync_clear;

  always_comb begin
    apply_src = APPLY_NONE;
    if (boundary) begin
      if (brg.div_load)  apply_src = APPLY_INPUT;
      else if (pending)  apply_src = APPLY_SHADOW;
    end
  end

  always_comb begin
    nxt_int  = act_int;
    nxt_frac = act_frac;
    case (apply_src)
      APPLY_INPUT: begin
        nxt_int  = brg.div_int;
        nxt_frac = brg.div_frac;
      end
      APPLY_SHADOW: begin
        nxt_int  = shd_int;
        nxt_frac = shd_frac;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_int  <= INT_WIDTH'(DEFAULT_INT);
      act_frac <= FRAC_WIDTH'(DEFAULT_FRAC);
      shd_int  <= '0;
      shd_frac <= '0;
      pending  <= 1'b0;
    end else begin
      if (brg.div_load) begin
        shd_int  <= brg.div_int;
        shd_frac <= brg.div_frac;
      end
      act_int  <= nxt_int;
      act_frac <= nxt_frac;
      pending  <= (brg.div_load | pending) & (apply_src == APPLY_NONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_count <= '0;
      sample_index <= '0;
    end else if (brg.sync_clear) begin
      period_count <= '0;
      sample_index <= '0;
    end else if (sample_tick) begin
      period_count <= '0;
      sample_index <= (sample_index == IDX_LAST) ? '0 : sample_index + 1'b1;
    end else if (brg.enable) begin
      period_count <= period_count + 1'b1;
    end
  end

  // The accumulate on a boundary uses the divisor being applied at that edge.
  uart_brg_frac_acc #(
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (brg.sync_clear),
    .advance  (sample_tick),
    .act_int  (act_int),
    .add_frac (nxt_frac),
    .len      (len)
  );

  assign brg.sample_tick  = sample_tick;
  assign brg.baud_tick    = sample_tick & (sample_index == IDX_LAST);
  assign brg.sample_index = sample_index;
  assign brg.period_count = period_count;
  assign brg.div_pending  = pending;

endmodule

// File: tb/tb_uart_brg_frac.sv
// Bench for uart_brg_frac: divisor table with a period scoreboard, plus
// hand sequences for reload timing, enable hold, resync and async reset.
module tb_uart_brg_frac;
  import uart_brg_frac_pkg::*;

  localparam int unsigned IW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_brg_frac_if #(.INT_WIDTH(IW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS)) bif ();

  uart_brg_frac #(
    .INT_WIDTH(IW), .FRAC_WIDTH(FW), .OVERSAMPLE(OS),
    .DEFAULT_INT(325), .DEFAULT_FRAC(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .brg   (bif)
  );

  typedef struct {
    int d_int;
    int d_frac;
    int exp_gap;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    #3;
  endtask

  // Expected length of period k (1-based): integer part plus the overflow
  // produced by the accumulate at the end of period k-1.
  task automatic push_periods(input int d_int, input int d_frac, input int n);
    int eff;
    eff = (d_int == 0) ? 1 : d_int;
    for (int k = 1; k <= n; k++) begin
      if (k == 1) exp_q.push_back(eff);
      else exp_q.push_back(eff + ((k - 1) * d_frac) / (1 << FW) - ((k - 2) * d_frac) / (1 << FW));
    end
  endtask

  task automatic load_and_clear(input int d_int, input int d_frac);
    bif.div_load = 1'b1;
    bif.div_int  = IW'(d_int);
    bif.div_frac = FW'(d_frac);
    step();
    bif.div_load   = 1'b0;
    bif.sync_clear = 1'b1;
    step();
    bif.sync_clear = 1'b0;
  endtask

  task automatic measure(input string tag, input int nper, output int gap);
    int since, cyc, ticks, budget, exp_idx, exp_first, stray;
    int baud_t[$];
    since = 0; cyc = 0; ticks = 0; exp_idx = 0; exp_first = 0; stray = 0; budget = 20;
    foreach (exp_q[i]) begin
      budget += exp_q[i];
      if (i < OS) exp_first += exp_q[i];
    end
    while (ticks < nper && cyc < budget) begin
      obs();
      since++;
      cyc++;
      if (bif.sample_tick) begin
        chk({tag, " period"}, since, exp_q.pop_front());
        chk({tag, " index"}, bif.sample_index, exp_idx);
        chk({tag, " baud"}, bif.baud_tick, (exp_idx == OS - 1) ? 1 : 0);
        if (bif.baud_tick) begin
          if (baud_t.size() == 0) chk({tag, " first_baud"}, cyc, exp_first);
          baud_t.push_back(cyc);
        end
        exp_idx = (exp_idx + 1) % OS;
        since = 0;
        ticks++;
      end else if (bif.baud_tick) begin
        stray++;
      end
      step();
    end
    chk({tag, " ticks_in_budget"}, ticks, nper);
    chk({tag, " stray_baud"}, stray, 0);
    gap = (baud_t.size() >= 2) ? baud_t[1] - baud_t[0] : 0;
    exp_q.delete();
  endtask

  task automatic cycles_to_tick(input int budget, output int n);
    n = 1;
    forever begin
      obs();
      if (bif.sample_tick || n >= budget) break;
      step();
      n++;
    end
    if (!bif.sample_tick) n = -1;
    step();
  endtask

  initial begin
    vec_t vecs[5];
    int gap, n, bad_pc, ticks_off, idx_hold;

    vecs[0] = '{d_int: 3, d_frac: 8,  exp_gap: 56};
    vecs[1] = '{d_int: 0, d_frac: 0,  exp_gap: 16};
    vecs[2] = '{d_int: 5, d_frac: 0,  exp_gap: 80};
    vecs[3] = '{d_int: 2, d_frac: 4,  exp_gap: 36};
    vecs[4] = '{d_int: 1, d_frac: 15, exp_gap: 31};

    bif.enable = 1'b1; bif.sync_clear = 1'b0; bif.div_load = 1'b0;
    bif.div_int = '0;  bif.div_frac = '0;

    // Reset state and default divisor 325 + 8/16.
    repeat (3) step();
    obs();
    chk("rst period_count", bif.period_count, 0);
    chk("rst sample_index", bif.sample_index, 0);
    chk("rst sample_tick", bif.sample_tick, 0);
    chk("rst baud_tick", bif.baud_tick, 0);
    chk("rst div_pending", bif.div_pending, 0);
    step();
    reset = 1'b1;
    push_periods(325, 8, 32);
    measure("default", 32, gap);
    chk("default baud_gap", gap, 5208);

    // Divisor table, each started from a clean phase.
    foreach (vecs[i]) begin
      load_and_clear(vecs[i].d_int, vecs[i].d_frac);
      push_periods(vecs[i].d_int, vecs[i].d_frac, 32);
      measure($sformatf("vec%0d", i), 32, gap);
      chk($sformatf("vec%0d baud_gap", i), gap, vecs[i].exp_gap);
    end

    // Mid-period reload 5 -> 2: old period completes first.
    load_and_clear(5, 0);
    step();
    bif.div_load = 1'b1; bif.div_int = IW'(2); bif.div_frac = '0;
    step();
    bif.div_load = 1'b0;
    obs();
    chk("midload pending", bif.div_pending, 1);
    chk("midload count", bif.period_count, 2);
    step(); step();
    obs();
    chk("midload old_end tick", bif.sample_tick, 1);
    chk("midload pending_at_end", bif.div_pending, 1);
    step();
    obs();
    chk("midload pending_clear", bif.div_pending, 0);
    step();
    // Reload coincident with the tick takes effect for the very next period.
    bif.div_load = 1'b1; bif.div_int = IW'(4); bif.div_frac = '0;
    obs();
    chk("midload new_len2 tick", bif.sample_tick, 1);
    step();
    bif.div_load = 1'b0;
    obs();
    chk("coinc pending", bif.div_pending, 0);
    chk("coinc count", bif.period_count, 0);
    cycles_to_tick(20, n);
    chk("coinc len4", n, 4);

    // Enable low for 10 cycles mid-period.
    step();
    obs();
    chk("hold start count", bif.period_count, 1);
    idx_hold = int'(bif.sample_index);
    bad_pc = 0; ticks_off = 0;
    bif.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      obs();
      if (bif.period_count != 1 || int'(bif.sample_index) != idx_hold) bad_pc++;
      if (bif.sample_tick || bif.baud_tick) ticks_off++;
      step();
    end
    chk("hold frozen", bad_pc, 0);
    chk("hold no_ticks", ticks_off, 0);
    bif.enable = 1'b1;
    cycles_to_tick(20, n);
    chk("hold remaining", n, 3);

    // sync_clear on a would-be baud tick.
    load_and_clear(0, 0);
    repeat (15) step();
    bif.sync_clear = 1'b1;
    obs();
    chk("sync idx15", bif.sample_index, 15);
    chk("sync tick_suppressed", bif.sample_tick, 0);
    chk("sync baud_suppressed", bif.baud_tick, 0);
    step();
    bif.sync_clear = 1'b0;
    obs();
    chk("sync count0", bif.period_count, 0);
    chk("sync idx0", bif.sample_index, 0);
    chk("sync baud_after", bif.baud_tick, 0);
    step();

    // Asynchronous reset mid-period drops a pending reload.
    load_and_clear(10, 0);
    repeat (3) step();
    bif.div_load = 1'b1; bif.div_int = IW'(2); bif.div_frac = '0;
    step();
    bif.div_load = 1'b0;
    obs();
    chk("arst pre pending", bif.div_pending, 1);
    chk("arst pre count", bif.period_count, 4);
    #1 reset = 1'b0;
    #1;
    chk("arst count", bif.period_count, 0);
    chk("arst index", bif.sample_index, 0);
    chk("arst pending", bif.div_pending, 0);
    chk("arst tick", bif.sample_tick, 0);
    step();
    reset = 1'b1;
    cycles_to_tick(400, n);
    chk("arst default_first", n, 325);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
